chip8_fetch: RTL

//  Instruction fetch stage of the CHIP-8 core; sits directly upstream of chip8_mem.

---
 rtl/chip8_fetch.sv | 127 ++++++++++++
 1 files changed

// File: rtl/chip8_fetch.sv
`default_nettype none
// ============================================================================
// Module   : chip8_fetch
// Purpose  : CHIP-8 instruction fetch. Reads two big-endian bytes from a
//            1-cycle-latency synchronous memory and presents one 16-bit
//            opcode over valid/ready. Owns the PC.
//            Optional pc_misalign output: CHIP8_FETCH_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module chip8_fetch #(
    parameter int                   ADDR_W   = 12,
    parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(12'h200)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [7:0]          mem_data,
    input  logic                pc_load,
    input  logic [ADDR_W-1:0]   pc_load_val,
    output logic [15:0]         instr,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [ADDR_W-1:0]   pc
`ifdef CHIP8_FETCH_ALIGN_CHECK_EN
    ,
    output logic                pc_misalign
`endif
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH_HI = 3'd1,
        S_FETCH_LO = 3'd2,
        S_CAPTURE  = 3'd3,
        S_HOLD     = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic [7:0]         r_hi;
    logic [7:0]         w_hi_nxt;
    logic [15:0]        r_instr;
    logic [15:0]        w_instr_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic [ADDR_W-1:0]  w_pc_inc1;
    logic [ADDR_W-1:0]  w_pc_inc2;

    // Increments wrap naturally at the PC width.
    assign w_pc_inc1 = r_pc + ADDR_W'(1);
    assign w_pc_inc2 = r_pc + ADDR_W'(2);

    assign mem_addr    = (r_state == S_FETCH_LO) ? w_pc_inc1 : r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_valid;
    assign pc          = r_pc;

`ifdef CHIP8_FETCH_ALIGN_CHECK_EN
    assign pc_misalign = r_valid & r_pc[0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_hi    <= 8'h00;
            r_instr <= 16'h0000;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_hi    <= w_hi_nxt;
            r_instr <= w_instr_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_hi_nxt    = r_hi;
        w_instr_nxt = r_instr;
        w_valid_nxt = r_valid;

        case (r_state)
            S_IDLE: begin
                if (fetch_en) w_state_nxt = S_FETCH_HI;
            end
            S_FETCH_HI: begin
                w_state_nxt = S_FETCH_LO;
            end
            S_FETCH_LO: begin
                w_hi_nxt    = mem_data;
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_instr_nxt = {r_hi, mem_data};
                w_valid_nxt = 1'b1;
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (r_valid && instr_ready) begin
                    w_valid_nxt = 1'b0;
                    w_pc_nxt    = w_pc_inc2;
                    w_state_nxt = fetch_en ? S_FETCH_HI : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // A redirect overrides everything, including a same-cycle accept;
        // the in-flight opcode is dropped and instr keeps its old value.
        if (pc_load) begin
            w_pc_nxt    = pc_load_val;
            w_valid_nxt = 1'b0;
            w_instr_nxt = r_instr;
            w_state_nxt = fetch_en ? S_FETCH_HI : S_IDLE;
        end
    end

endmodule
`default_nettype wire
